// File: rtl/iseq_dispatcher.sv
// iseq_dispatcher
//   Sequences 32-bit SoftMC instructions from the instruction FIFO into the
//   DFI instruction decoder. DDR command words are forwarded as one-cycle
//   dec_en pulses. WAIT, BUSDIR and END are executed locally.
//
// Parameters
//   WAIT_WIDTH : width of the WAIT cycle-count field instr[WAIT_WIDTH-1:0]
//   CNT_WIDTH  : width of the saturating issued-command counter
//
// Ports
//   clk, rst   : clock and synchronous active-high reset
//   start      : pulse that begins a sequence (honoured only in IDLE)
//   in_valid / in_instr / in_ready : instruction handshake
//   dec_en / dec_instr : decoder enable pulse and instruction
//   busdir     : DQ bus direction (0 = read, 1 = write)
//   busy       : sequence in progress (RUN or WAIT)
//   done       : one-cycle pulse when the sequence ends
//   cmd_count  : DDR commands issued since the last start (saturating)
//   err        : sticky illegal-opcode flag
//
// Build option
//   ILLEGAL_TRAP_EN : when defined, an illegal opcode aborts the sequence
//                     to DONE; otherwise it only sets err and is skipped.
module iseq_dispatcher #(
  parameter int WAIT_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [31:0]          in_instr,
  output logic                 in_ready,
  output logic                 dec_en,
  output logic [31:0]          dec_instr,
  output logic                 busdir,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] cmd_count,
  output logic                 err
);

  localparam logic [3:0] OP_DDR    = 4'b0001;
  localparam logic [3:0] OP_WAIT   = 4'b0010;
  localparam logic [3:0] OP_BUSDIR = 4'b0100;
  localparam logic [3:0] OP_END    = 4'b1000;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [WAIT_WIDTH-1:0] WAIT_ONE = WAIT_WIDTH'(1);
  localparam logic [WAIT_WIDTH-1:0] WAIT_ZERO = {WAIT_WIDTH{1'b0}};

  logic [1:0]            state;
  logic [WAIT_WIDTH-1:0] wait_cnt;

  logic                  accept;
  logic [3:0]            opcode;
  logic [WAIT_WIDTH-1:0] wait_n;

  // in_ready is only ever high in RUN, so accept implies RUN.
  assign accept = in_valid && in_ready;
  assign opcode = in_instr[31:28];
  assign wait_n = in_instr[WAIT_WIDTH-1:0];

  // Sequencer state machine and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= WAIT_ZERO;
      in_ready  <= 1'b0;
      dec_en    <= 1'b0;
      dec_instr <= 32'h0000_0000;
      busdir    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_count <= {CNT_WIDTH{1'b0}};
      err       <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      dec_en <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_RUN;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            cmd_count <= {CNT_WIDTH{1'b0}};
            err       <= 1'b0;
          end
        end
        S_RUN: begin
          if (accept) begin
            case (opcode)
              OP_DDR: begin
                dec_en    <= 1'b1;
                dec_instr <= in_instr;
                if (cmd_count != CNT_MAX) begin
                  cmd_count <= cmd_count + CNT_ONE;
                end
              end
              OP_WAIT: begin
                // WAIT 0 is a no-op: stay in RUN with in_ready held high.
                if (wait_n != WAIT_ZERO) begin
                  wait_cnt <= wait_n;
                  state    <= S_WAIT;
                  in_ready <= 1'b0;
                end
              end
              OP_BUSDIR: begin
                busdir <= in_instr[0];
              end
              OP_END: begin
                state    <= S_DONE;
                done     <= 1'b1;
                busy     <= 1'b0;
                in_ready <= 1'b0;
              end
              default: begin
                err <= 1'b1;
`ifdef ILLEGAL_TRAP_EN
                state    <= S_DONE;
                done     <= 1'b1;
                busy     <= 1'b0;
                in_ready <= 1'b0;
`endif
              end
            endcase
          end
        end
        S_WAIT: begin
          // Leaving on count 1 re-opens in_ready exactly N cycles after
          // the WAIT was accepted.
          if (wait_cnt == WAIT_ONE) begin
            wait_cnt <= WAIT_ZERO;
            state    <= S_RUN;
            in_ready <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - WAIT_ONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iseq_dispatcher.sv
// tb_iseq_dispatcher
//   Drives directed and random instruction streams into iseq_dispatcher and
//   compares every output, every cycle, against a transaction-level model
//   that tracks "ready from cycle" arithmetic instead of a down-counter.
module tb_iseq_dispatcher;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        dec_en;
  logic [31:0] dec_instr;
  logic        busdir;
  logic        busy;
  logic        done;
  logic [15:0] cmd_count;
  logic        err;

  iseq_dispatcher #(.WAIT_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .dec_en    (dec_en),
    .dec_instr (dec_instr),
    .busdir    (busdir),
    .busy      (busy),
    .done      (done),
    .cmd_count (cmd_count),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  int cyc;

  // Reference model state
  bit          m_running;
  int          m_ready_from;
  bit          m_done;
  bit          m_dec_en;
  logic [31:0] m_dec_instr;
  bit          m_busdir;
  int          m_cnt;
  bit          m_err;
  bit          m_took;

  localparam int CNT_MAX = 65535;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit exp_ready();
    return m_running && (cyc >= m_ready_from);
  endfunction

  function automatic bit m_idle();
    return !m_running && !m_done;
  endfunction

  task automatic model_reset();
    m_running    = 1'b0;
    m_ready_from = 0;
    m_done       = 1'b0;
    m_dec_en     = 1'b0;
    m_dec_instr  = 32'h0;
    m_busdir     = 1'b0;
    m_cnt        = 0;
    m_err        = 1'b0;
  endtask

  // Applies the inputs present during cycle cyc and predicts cycle cyc+1.
  task automatic model_update();
    bit acc;
    bit was_idle;
    acc      = exp_ready() && in_valid;
    was_idle = m_idle();
    m_took   = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      m_done   = 1'b0;
      m_dec_en = 1'b0;
      if (was_idle && start) begin
        m_running    = 1'b1;
        m_ready_from = cyc + 1;
        m_cnt        = 0;
        m_err        = 1'b0;
      end
      if (acc) begin
        m_took = 1'b1;
        case (in_instr[31:28])
          4'b0001: begin
            m_dec_en    = 1'b1;
            m_dec_instr = in_instr;
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
          end
          4'b0010: m_ready_from = cyc + 1 + int'(in_instr[15:0]);
          4'b0100: m_busdir = in_instr[0];
          4'b1000: begin
            m_running = 1'b0;
            m_done    = 1'b1;
          end
          default: begin
            m_err = 1'b1;
`ifdef ILLEGAL_TRAP_EN
            m_running = 1'b0;
            m_done    = 1'b1;
`endif
          end
        endcase
      end
    end
  endtask

  task automatic compare_all();
    check_eq("in_ready",  {31'd0, in_ready}, {31'd0, exp_ready()});
    check_eq("busy",      {31'd0, busy},     {31'd0, m_running});
    check_eq("done",      {31'd0, done},     {31'd0, m_done});
    check_eq("dec_en",    {31'd0, dec_en},   {31'd0, m_dec_en});
    check_eq("dec_instr", dec_instr,         m_dec_instr);
    check_eq("busdir",    {31'd0, busdir},   {31'd0, m_busdir});
    check_eq("cmd_count", {16'd0, cmd_count}, m_cnt[31:0]);
    check_eq("err",       {31'd0, err},      {31'd0, m_err});
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    cyc++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Presents one word and holds it until the model says it was accepted.
  task automatic send(input logic [31:0] w);
    int n;
    in_valid = 1'b1;
    in_instr = w;
    n = 0;
    tick();
    while (!m_took && n < 300) begin
      tick();
      n++;
    end
    if (!m_took) check_eq("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic go_idle();
    if (m_running) send(32'h8000_0000);
    idle_ticks(3);
  endtask

  function automatic logic [31:0] rand_instr();
    int r;
    logic [3:0]  op;
    logic [27:0] body;
    r    = $urandom_range(0, 15);
    body = 28'($urandom);
    if (r < 7)       op = 4'b0001;
    else if (r < 10) begin
      op   = 4'b0010;
      body = {12'($urandom), 16'($urandom_range(0, 6))};
    end
    else if (r < 13) op = 4'b0100;
    else if (r < 14) op = 4'b1000;
    else begin
      op = 4'($urandom);
      while (op == 4'b0001 || op == 4'b0010 || op == 4'b0100 || op == 4'b1000)
        op = 4'($urandom);
    end
    return {op, body};
  endfunction

  logic [31:0] cur_word;

  initial begin
    total    = 0;
    bad      = 0;
    cyc      = 0;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_instr = 32'h0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    idle_ticks(2);

    // Two DDR commands then END on consecutive cycles
    pulse_start();
    send(32'h1000_0123);
    send(32'h1000_0456);
    send(32'h8000_0000);
    idle_ticks(3);
    check_eq("two_cmds", {16'd0, cmd_count}, 32'd2);

    // DDR, WAIT 5, DDR, WAIT 0, DDR
    pulse_start();
    send(32'h1000_0001);
    send(32'h2000_0005);
    send(32'h1000_0002);
    send(32'h2000_0000);
    send(32'h1000_0003);
    send(32'h8000_0000);
    idle_ticks(3);

    // BUSDIR up then down
    pulse_start();
    send(32'h4000_0001);
    send(32'h4000_0000);
    send(32'h8000_0000);
    idle_ticks(3);

    // Illegal opcode mid-sequence
    pulse_start();
    send(32'h1000_0011);
    send(32'hF000_0000);
`ifdef ILLEGAL_TRAP_EN
    in_valid = 1'b1;
    in_instr = 32'h1000_0022;
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1'b0;
`else
    send(32'h1000_0022);
    send(32'h8000_0000);
`endif
    idle_ticks(3);
    check_eq("err_sticky", {31'd0, err}, 32'd1);

    // Reset in the middle of WAIT 100
    pulse_start();
    send(32'h2000_0064);
    idle_ticks(10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_ready", {31'd0, in_ready}, 32'd0);
    idle_ticks(2);
    pulse_start();
    send(32'h1000_0777);
    send(32'h8000_0000);
    idle_ticks(3);

    // Random traffic
    m_took = 1'b1;
    cur_word = 32'h0;
    for (int i = 0; i < 4000; i++) begin
      start = m_idle() && ($urandom_range(0, 3) == 0);
      if (m_took) cur_word = rand_instr();
      in_valid = ($urandom_range(0, 4) != 0);
      in_instr = cur_word;
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    go_idle();

    // Saturation of the command counter
    pulse_start();
    in_valid = 1'b1;
    in_instr = 32'h1000_00AA;
    for (int i = 0; i < 65537; i++) tick();
    in_valid = 1'b0;
    tick();
    check_eq("cnt_sat", {16'd0, cmd_count}, 32'h0000_FFFF);
    send(32'h8000_0000);
    idle_ticks(3);
    check_eq("cnt_hold_idle", {16'd0, cmd_count}, 32'h0000_FFFF);
    pulse_start();
    check_eq("cnt_clear", {16'd0, cmd_count}, 32'd0);
    send(32'h8000_0000);
    idle_ticks(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iseq_dispatcher.md
# iseq_dispatcher

Sequences a stream of 32-bit SoftMC instructions into the DFI command decoder. Accepts instructions over a valid/ready handshake, forwards DDR command instructions to the decoder as one-cycle enable pulses, and executes the control instructions locally: WAIT cycle delays, bus-direction changes and END of sequence. It sits between the instruction FIFO and the DFI instruction decoder.

## Interface
- `WAIT_WIDTH`, 16: width of the WAIT cycle count field, `instr[WAIT_WIDTH-1:0]`.
- `CNT_WIDTH`, 16: width of the issued-command counter.
- `clk` input 1: clock; all logic is on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: single-cycle pulse that begins a sequence; ignored unless in IDLE.
- `in_valid` input 1: instruction available.
- `in_instr` input 32: instruction word.
- `in_ready` output 1: dispatcher accepts `in_instr` this cycle.
- `dec_en` output 1: enable to the decoder; one-cycle pulse per DDR command.
- `dec_instr` output 32: instruction presented to the decoder.
- `busdir` output 1: DQ bus direction, 0 = read, 1 = write.
- `busy` output 1: a sequence is in progress (RUN or WAIT).
- `done` output 1: one-cycle pulse when END executes.
- `cmd_count` output CNT_WIDTH: DDR commands issued since the last `start`; saturates at all-ones.
- `err` output 1: sticky illegal-opcode flag.

## Operation
- Opcode field is `instr[31:28]`:
  - 4'b0001: DDR command.
  - 4'b0010: WAIT.
  - 4'b0100: BUSDIR.
  - 4'b1000: END.
  - Any other value is illegal.
- Handshake: an instruction transfers when `in_valid && in_ready` on a clock edge.
- States: IDLE, RUN, WAIT, DONE.
- IDLE:
  - `in_ready`=0 and `busy`=0.
  - On `start` go to RUN: `cmd_count` clears to 0 and `err` clears to 0.
- RUN: `in_ready`=1. The accepted opcode selects the action:
  - DDR: `dec_instr` is loaded with `in_instr` and `dec_en`=1 on the next cycle only. `cmd_count` increments, holding at max when already at max. Stay in RUN.
  - WAIT with N=`instr[WAIT_WIDTH-1:0]`: if N=0, stay in RUN (no-op). Otherwise load the down-counter with N and go to WAIT.
  - BUSDIR: `busdir` <= `instr[0]`; stay in RUN.
  - END: go to DONE.
  - Illegal: `err` <= 1; the instruction is dropped (see Configuration).
- WAIT:
  - `in_ready`=0.
  - The counter decrements each cycle; on reaching 0, return to RUN.
- DONE:
  - `done`=1 for one cycle, then go to IDLE.
  - `in_ready`=0.
- `dec_instr` holds its last value while `dec_en`=0.
- `start` while not in IDLE is ignored.
- `in_valid` while `in_ready`=0 is not consumed. The source must hold the word stable until it is accepted.

## Timing
- All outputs are registered.
- Reset values: `in_ready`=0, `dec_en`=0, `dec_instr`=0, `busdir`=0, `busy`=0, `done`=0, `cmd_count`=0, `err`=0; state = IDLE; WAIT counter = 0.
- `start` at cycle t: `busy`=1 and `in_ready`=1 at t+1.
- DDR command accepted at t: `dec_en`=1 at t+1. Back-to-back DDR commands give `dec_en` high on consecutive cycles.
- WAIT N accepted at t: `in_ready`=0 for cycles t+1 through t+N; the next accept is possible at t+N+1.
- BUSDIR accepted at t: `busdir` changes at t+1.
- END accepted at t:
  - `done`=1 at t+1.
  - `busy`=0 and `in_ready`=0 from t+1.
  - A DDR command accepted at t-1 still pulses `dec_en` at t.
- `rst` asserted in any state, including mid-WAIT or during a `dec_en` pulse: all outputs return to their reset values on the next edge. The pending wait is discarded.

## Configuration
- `ILLEGAL_TRAP_EN` defined:
  - An illegal opcode sets `err` and aborts the sequence to DONE.
  - `done` pulses at t+1 and the machine then returns to IDLE.
- `ILLEGAL_TRAP_EN` undefined:
  - An illegal opcode sets `err`.
  - It is otherwise treated as a no-op; the machine stays in RUN.

## Test plan
- `start`, then DDR 0x1000_0123, DDR 0x1000_0456, END on consecutive cycles -> `dec_en` high for 2 cycles with `dec_instr` 0x1000_0123 then 0x1000_0456; `cmd_count`=2; `done` pulses once.
- DDR, WAIT 5, DDR -> second `dec_en` pulse exactly 7 cycles after the first. WAIT 0 adds no cycle.
- BUSDIR 0x4000_0001, then BUSDIR 0x4000_0000 -> `busdir` rises 1 cycle after the first accept and falls 1 cycle after the second.
- Opcode 0xF inserted mid-sequence:
  - With `ILLEGAL_TRAP_EN`: `err`=1 and `done` at t+1; later DDR words are not accepted.
  - Without `ILLEGAL_TRAP_EN`: `err`=1 and the following DDR word issues normally.
- `rst` pulsed during WAIT 100 -> the next cycle shows every output at its reset value and IDLE; a fresh `start` runs normally.
- 65 537 DDR commands with `CNT_WIDTH`=16 -> `cmd_count` saturates at 0xFFFF; `start` in IDLE clears it to 0.
